apb_rate_delayer: RTL

- Parametrised APB timing-scaling bridge placed between the APB master and a slow peripheral.
- Forwards each transfer downstream and counts the cycles the peripheral takes. It then stalls the upstream completion so the total latency is scaled by a fixed-point ratio R (real-device speed / sim clock).
- Successor to the fixed-width delayer:
  - width-generic;
  - fraction carried across transactions;
  - saturating counter;
  - registered pslverr;
  - optional runtime ratio.

---
 rtl/apb_rate_delayer_pkg.sv | 27 ++
 rtl/apb_rate_delayer_delay_accum.sv | 48 ++++
 rtl/apb_rate_delayer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/apb_rate_delayer_pkg.sv
// Shared types and helpers for the APB rate delayer: FSM state encoding,
// default counter geometry and a width-generic saturating adder.
package apb_rate_delayer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam int R_INT_W_DEF  = 12;
  localparam int R_FRAC_W_DEF = 4;
  localparam int CNT_W        = R_INT_W_DEF + R_FRAC_W_DEF;

  // Adds two unsigned values of width w (w <= 32) and clamps at all-ones.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/apb_rate_delayer_delay_accum.sv
// Fixed-point delay accumulator: saturating add of the ratio, whole-cycle
// decrement of the integer part, and integer clear that keeps the fraction.
module delay_accum
  import apb_rate_delayer_pkg::*;
#(
  parameter int R_INT_W  = R_INT_W_DEF,
  parameter int R_FRAC_W = R_FRAC_W_DEF
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        add_en,
  input  logic                        dec_en,
  input  logic                        clr_int,
  input  logic [R_INT_W+R_FRAC_W-1:0] r,
  output logic                        int_zero,
  output logic [R_INT_W+R_FRAC_W-1:0] cnt
);

  localparam int CW = R_INT_W + R_FRAC_W;
  localparam logic [CW-1:0] ONE_INT   = CW'(1) << R_FRAC_W;
  localparam logic [CW-1:0] FRAC_MASK = ONE_INT - CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign int_zero = ((cnt_q >> R_FRAC_W) == '0);
  assign cnt      = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (add_en) begin
      cnt_d = CW'(sat_add(32'(cnt_q), 32'(r), CW));
    end else if (clr_int) begin
      cnt_d = cnt_q & FRAC_MASK;
    end else if (dec_en && !int_zero) begin
      cnt_d = cnt_q - ONE_INT;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_rate_delayer.sv
// APB bridge that stretches each transfer's completion so total latency scales
// by a fixed-point ratio. Define APB_RATE_DELAYER_DYN_RATIO_EN for a runtime ratio.
module apb_rate_delayer
  import apb_rate_delayer_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int R_INT_W  = R_INT_W_DEF,
  parameter int R_FRAC_W = R_FRAC_W_DEF,
  parameter logic [R_INT_W+R_FRAC_W-1:0] R_DEFAULT = 16'h002A
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   in_paddr,
  input  logic                in_psel,
  input  logic                in_penable,
  input  logic [2:0]          in_pprot,
  input  logic                in_pwrite,
  input  logic [DATA_W-1:0]   in_pwdata,
  input  logic [DATA_W/8-1:0] in_pstrb,
  output logic                in_pready,
  output logic [DATA_W-1:0]   in_prdata,
  output logic                in_pslverr,
  output logic [ADDR_W-1:0]   out_paddr,
  output logic                out_psel,
  output logic                out_penable,
  output logic [2:0]          out_pprot,
  output logic                out_pwrite,
  output logic [DATA_W-1:0]   out_pwdata,
  output logic [DATA_W/8-1:0] out_pstrb,
  input  logic                out_pready,
  input  logic [DATA_W-1:0]   out_prdata,
  input  logic                out_pslverr,
  output logic [1:0]          state
`ifdef APB_RATE_DELAYER_DYN_RATIO_EN
  , input logic [R_INT_W+R_FRAC_W-1:0] cfg_ratio
`endif
);

  localparam int CW = R_INT_W + R_FRAC_W;

  state_e          state_q;
  state_e          state_d;
  logic [CW-1:0]   r_cur;
  logic [CW-1:0]   cnt;
  logic            int_zero;
  logic            add_en;
  logic            dec_en;
  logic            clr_int;
  logic            pass_en;
  logic [DATA_W-1:0] cap_rdata;
  logic            cap_err;

`ifdef APB_RATE_DELAYER_DYN_RATIO_EN
  logic [CW-1:0] r_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q <= R_DEFAULT;
    end else if (state_q == ST_IDLE && in_psel) begin
      r_q <= cfg_ratio;
    end
  end

  // The IDLE add happens on the latch cycle itself, so it sees the live value.
  assign r_cur = (state_q == ST_IDLE) ? cfg_ratio : r_q;
`else
  assign r_cur = R_DEFAULT;
`endif

  assign add_en  = (state_q == ST_IDLE && in_psel) || (state_q == ST_FWD);
  assign dec_en  = (state_q == ST_WAIT) && !int_zero;
  assign clr_int = (state_q == ST_RESP);

  delay_accum #(
    .R_INT_W (R_INT_W),
    .R_FRAC_W(R_FRAC_W)
  ) u_accum (
    .clock   (clock),
    .reset   (reset),
    .add_en  (add_en),
    .dec_en  (dec_en),
    .clr_int (clr_int),
    .r       (r_cur),
    .int_zero(int_zero),
    .cnt     (cnt)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_psel)    state_d = ST_FWD;
      ST_FWD:  if (out_pready) state_d = ST_WAIT;
      ST_WAIT: if (int_zero)   state_d = ST_RESP;
      ST_RESP:                 state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cap_rdata <= '0;
      cap_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_FWD && out_pready) begin
        cap_rdata <= out_prdata;
        cap_err   <= out_pslverr;
      end
    end
  end

  // Downstream only sees select/enable until the peripheral has answered.
  assign pass_en     = (state_q == ST_IDLE) || (state_q == ST_FWD);
  assign out_psel    = pass_en && in_psel;
  assign out_penable = pass_en && in_penable;
  assign out_paddr   = in_paddr;
  assign out_pprot   = in_pprot;
  assign out_pwrite  = in_pwrite;
  assign out_pwdata  = in_pwdata;
  assign out_pstrb   = in_pstrb;

  assign in_pready  = (state_q == ST_RESP);
  assign in_prdata  = (state_q == ST_RESP) ? cap_rdata : '0;
  assign in_pslverr = (state_q == ST_RESP) && cap_err;

  assign state = state_q;

  logic unused_cnt;
  assign unused_cnt = ^cnt;

endmodule
